// File: rtl/lc3_fetch_pkg.sv
// Shared types for the LC-3 instruction-fetch stage.
//   fetch_state_t    : fetch FSM states (idle after reset, running, one-cycle flush).
//   fetch_entry_t    : one buffered instruction with the PC+1 it was fetched at.
//   PC_RESET_DEFAULT : default PC after reset.
package lc3_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } fetch_entry_t;

  localparam logic [15:0] PC_RESET_DEFAULT = 16'h3000;

endpackage

// File: rtl/lc3_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory, the redirect source and decode.
//   master : fetch-stage view (drives imem_rd/imem_addr and the decode-side outputs).
//   slave  : environment view (memory, branch unit, decode).
interface lc3_fetch_if;

  logic        enable_fetch;
  logic        enable_updatePC;
  logic        br_taken;
  logic [15:0] taddr;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_dout;
  logic        decode_ready;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_out;

  modport master (
    input  enable_fetch, enable_updatePC, br_taken, taddr, imem_dout, decode_ready,
    output imem_rd, imem_addr, enable_decode, dout, npc_out
  );

  modport slave (
    output enable_fetch, enable_updatePC, br_taken, taddr, imem_dout, decode_ready,
    input  imem_rd, imem_addr, enable_decode, dout, npc_out
  );

endinterface

// File: rtl/lc3_fetch_buf.sv
// Instruction buffer: small synchronous FIFO of fetch_entry_t.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   push, data   : append an entry (caller guarantees it is never full)
//   pop          : drop the head (caller guarantees it is never empty)
//   clear        : empty the buffer at the edge; overrides push/pop
//   head         : current head entry, read straight from storage flops
//   count        : number of valid entries
module lc3_fetch_buf
  import lc3_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             data,
  input  logic                     pop,
  input  logic                     clear,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t          mem_q [DEPTH];
  logic [PW-1:0]         rd_q, wr_q;
  logic [PW:0]           count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // Storage is reset so the head reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (clear) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= data;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/lc3_fetch_stage.sv
// LC-3 instruction-fetch stage: owns the PC, issues one-cycle-latency reads to instruction
// memory and queues {instr, PC+1} for decode. A qualified branch redirects the PC and drops
// everything buffered or in flight.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus (master) : enable_fetch/enable_updatePC/br_taken/taddr control inputs,
//                  imem_rd/imem_addr/imem_dout memory port,
//                  decode_ready/enable_decode/dout/npc_out decode handshake
module lc3_fetch_stage
  import lc3_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  lc3_fetch_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH);
  localparam logic [CW+1:0] DepthW = DEPTH[CW+1:0];

  fetch_state_t  state_q;
  logic [15:0]   pc_q;
  logic [15:0]   npc_q;
  logic          inflight_q;

  logic          redirect;
  logic          issue;
  logic          pop;
  logic          push;
  logic          has_head;
  logic [CW:0]   buf_count;
  logic [CW+1:0] occupancy;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign redirect = bus.br_taken & bus.enable_updatePC;
  assign has_head = (buf_count != '0);
  assign pop      = has_head & bus.decode_ready;

  // Slots committed once this cycle's pop retires: buffered plus the read still in flight.
  assign occupancy = {1'b0, buf_count} + {{(CW+1){1'b0}}, inflight_q}
                   - {{(CW+1){1'b0}}, pop};

  assign issue = (state_q != StIdle) & bus.enable_fetch & bus.enable_updatePC &
                 ~bus.br_taken & (occupancy < DepthW);

  // A response returning in the redirect cycle belongs to the old stream.
  assign push       = inflight_q & ~redirect & (state_q != StFlush);
  assign push_entry = '{instr: bus.imem_dout, npc: npc_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= PC_RESET;
      npc_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) npc_q <= pc_q + 16'd1;

      if (redirect)   pc_q <= bus.taddr;
      else if (issue) pc_q <= pc_q + 16'd1;

      if (redirect) begin
        state_q <= StFlush;
      end else begin
        unique case (state_q)
          StIdle:  if (bus.enable_fetch) state_q <= StRun;
          StRun:   state_q <= StRun;
          StFlush: state_q <= StRun;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  lc3_fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .data  (push_entry),
    .pop   (pop),
    .clear (redirect),
    .head  (head),
    .count (buf_count)
  );

  assign bus.imem_rd       = issue;
  assign bus.imem_addr     = pc_q;
  assign bus.enable_decode = has_head;
  assign bus.dout          = head.instr;
  assign bus.npc_out       = head.npc;

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// Self-checking bench for lc3_fetch_stage: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_lc3_fetch_stage;
  import lc3_fetch_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clock = 1'b0;
  logic reset;

  lc3_fetch_if bus ();

  lc3_fetch_stage #(
    .DEPTH    (DEPTH),
    .PC_RESET (16'h3000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Instruction memory: synchronous read, data valid the cycle after imem_rd.
  logic [15:0] mem_rdata = 16'h0000;
  always @(posedge clock) if (bus.imem_rd) mem_rdata <= mem_fn(bus.imem_addr);
  assign bus.imem_dout = mem_rdata;

  // Reference model state.
  fetch_entry_t m_q[$];
  logic [15:0]  m_pc;
  logic [15:0]  m_ipc;
  bit           m_inflight;
  bit           m_started;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = 16'h3000;
    m_ipc      = 16'h0000;
    m_inflight = 1'b0;
    m_started  = 1'b0;
  endtask

  // Apply one cycle of inputs (called just after a falling edge), check, advance the model.
  task automatic step(input logic ef, input logic upd, input logic br,
                      input logic [15:0] ta, input logic rdy);
    bit exp_dec, pop, redir, exp_issue;
    int occ;
    bus.enable_fetch    = ef;
    bus.enable_updatePC = upd;
    bus.br_taken        = br;
    bus.taddr           = ta;
    bus.decode_ready    = rdy;
    #1;
    exp_dec   = (m_q.size() != 0);
    pop       = exp_dec && rdy;
    redir     = br && upd;
    occ       = m_q.size() + int'(m_inflight) - int'(pop);
    exp_issue = m_started && ef && upd && !br && (occ < int'(DEPTH));

    check("imem_rd", 32'(bus.imem_rd), 32'(exp_issue));
    check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    check("enable_decode", 32'(bus.enable_decode), 32'(exp_dec));
    if (exp_dec) begin
      check("dout", 32'(bus.dout), 32'(m_q[0].instr));
      check("npc_out", 32'(bus.npc_out), 32'(m_q[0].npc));
    end
    check("no_push_full", 32'(dut.push && (32'(dut.buf_count) == DEPTH)), 32'd0);

    if (pop) void'(m_q.pop_front());
    if (redir) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pc       = ta;
    end else begin
      if (m_inflight) m_q.push_back('{instr: mem_fn(m_ipc), npc: m_ipc + 16'd1});
      if (exp_issue) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 16'd1;
      end
      m_inflight = exp_issue;
    end
    if (ef) m_started = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'h3000);
    check({tag, "_imem_rd"}, 32'(bus.imem_rd), 32'd0);
    check({tag, "_enable_decode"}, 32'(bus.enable_decode), 32'd0);
    check({tag, "_dout"}, 32'(bus.dout), 32'd0);
    check({tag, "_npc_out"}, 32'(bus.npc_out), 32'd0);
  endtask

  initial begin
    bit ef, upd, br, rdy;
    logic [15:0] ta;

    reset               = 1'b0;
    bus.enable_fetch    = 1'b0;
    bus.enable_updatePC = 1'b0;
    bus.br_taken        = 1'b0;
    bus.taddr           = 16'h0000;
    bus.decode_ready    = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Sequential streaming with decode always ready.
    repeat (8) step(1, 1, 0, 16'h0000, 1);
    // Decode stalls: buffer fills, issue stops, head holds; then drains.
    repeat (6) step(1, 1, 0, 16'h0000, 0);
    repeat (6) step(1, 1, 0, 16'h0000, 1);
    // Redirect with data buffered and a read in flight.
    step(1, 1, 0, 16'h0000, 0);
    step(1, 1, 1, 16'h4010, 0);
    repeat (6) step(1, 1, 0, 16'h0000, 1);
    // Branch without enable_updatePC is ignored.
    repeat (2) step(1, 0, 1, 16'h5555, 1);
    repeat (3) step(1, 1, 0, 16'h0000, 1);
    // Redirect near the top of memory: PC wraps.
    step(1, 1, 1, 16'hFFFE, 1);
    repeat (6) step(1, 1, 0, 16'h0000, 1);
    // Asynchronous reset mid-stream with entries buffered.
    repeat (4) step(1, 1, 0, 16'h0000, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) step(1, 1, 0, 16'h0000, 1);

    // Random traffic.
    repeat (400) begin
      ef  = ($urandom_range(0, 7) != 0);
      upd = ($urandom_range(0, 7) != 0);
      br  = m_started && ($urandom_range(0, 15) == 0);
      ta  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      step(ef, upd, br, ta, rdy);
    end
    // Drain whatever is left.
    repeat (6) step(0, 1, 0, 16'h0000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
